// File: rtl/rv_debug_pkg.sv
// Shared debug-side definitions for the register-file dump/load engines.
package rv_debug_pkg;

  localparam int REG_COUNT  = 32;
  localparam int REG_ADDR_W = 5;
  localparam int XLEN       = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    SEND = 2'd2,
    FIN  = 2'd3
  } dump_state_e;

endpackage

// File: rtl/regfile_dump_reader.sv
// Walks a contiguous range of the register file through a borrowed read port
// and streams each word out over a valid/ready interface.
module regfile_dump_reader
  import rv_debug_pkg::*;
#(
  parameter int DATA_W    = XLEN,
  parameter int ADDR_W    = REG_ADDR_W,
  parameter int FIRST_REG = 0,
  parameter int LAST_REG  = REG_COUNT - 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  output logic [ADDR_W-1:0] dbg_raddr,
  input  logic [DATA_W-1:0] dbg_rdata,
  output logic              busy,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0] out_index,
  output logic              done
);

  localparam logic [ADDR_W-1:0] FirstIdx = ADDR_W'(FIRST_REG);
  localparam logic [ADDR_W-1:0] LastIdx  = ADDR_W'(LAST_REG);

  dump_state_e       state, stateNext;
  logic [ADDR_W-1:0] idx, idxNext;
  logic              validNext, doneNext;
  logic [DATA_W-1:0] dataNext;
  logic [ADDR_W-1:0] indexNext;

  assign dbg_raddr = idx;
  assign busy      = (state != IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      idx       <= FirstIdx;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_index <= '0;
      done      <= 1'b0;
    end else begin
      state     <= stateNext;
      idx       <= idxNext;
      out_valid <= validNext;
      out_data  <= dataNext;
      out_index <= indexNext;
      done      <= doneNext;
    end
  end

  // Abort wins over everything outside IDLE; a word accepted on the abort edge still counts.
  always_comb begin
    stateNext = state;
    idxNext   = idx;
    validNext = out_valid;
    dataNext  = out_data;
    indexNext = out_index;
    doneNext  = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          idxNext   = FirstIdx;
          stateNext = READ;
        end
      end
      READ: begin
        if (abort) begin
          validNext = 1'b0;
          stateNext = IDLE;
        end else begin
          dataNext  = dbg_rdata;
          indexNext = idx;
          validNext = 1'b1;
          stateNext = SEND;
        end
      end
      SEND: begin
        if (abort) begin
          validNext = 1'b0;
          stateNext = IDLE;
        end else if (out_valid && out_ready) begin
          validNext = 1'b0;
          if (idx == LastIdx) begin
            doneNext  = 1'b1;
            stateNext = FIN;
          end else begin
            idxNext   = idx + 1'b1;
            stateNext = READ;
          end
        end
      end
      FIN: begin
        stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Self-checking bench for regfile_dump_reader: cycle table, directed corner
// sequences and randomized dumps against a word-queue reference model.
module tb_regfile_dump_reader;

  localparam int DW    = 32;
  localparam int AW    = 5;
  localparam int FIRST = 0;
  localparam int LAST  = 31;
  localparam int NREG  = LAST - FIRST + 1;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic          abort;
  logic [AW-1:0] dbg_raddr;
  logic [DW-1:0] dbg_rdata;
  logic          busy;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [AW-1:0] out_index;
  logic          done;

  logic [DW-1:0] regs [32];

  int compared   = 0;
  int mismatched = 0;

  assign dbg_rdata = regs[dbg_raddr];

  always #5 clk = ~clk;

  regfile_dump_reader #(
    .DATA_W(DW), .ADDR_W(AW), .FIRST_REG(FIRST), .LAST_REG(LAST)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .dbg_raddr(dbg_raddr), .dbg_rdata(dbg_rdata), .busy(busy),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_index(out_index), .done(done)
  );

  typedef struct {
    bit            start;
    bit            abort;
    bit            ready;
    bit            expBusy;
    bit            expValid;
    logic [AW-1:0] expRaddr;
    logic [AW-1:0] expIndex;
    logic [DW-1:0] expData;
  } vec_t;

  task automatic checkOutput(input string name, input logic [DW-1:0] actual,
                             input logic [DW-1:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic loadRegs(input bit randomFill);
    for (int i = 0; i < 32; i++)
      regs[i] = randomFill ? $urandom : 32'h1000_0000 + i;
    regs[0] = '0;
  endtask

  // One dump driven from IDLE; the model is just the ordered list of expected words.
  task automatic applyStimulus(input int readyPct, input int stallIdx, input int startIdx,
                               input int abortIdx, input int resetIdx, input bit checkTiming);
    int expIdx = FIRST;
    int words = 0;
    int cyc = 0;
    int doneCycle = -1;
    int stallLeft = 0;
    bit stallUsed = 0;
    bit startUsed = 0;
    bit prevValid = 0;
    bit prevHs = 0;
    bit finished = 0;
    start = 1'b1; abort = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    while (!finished && cyc < 600) begin
      checkOutput("busy", busy, 1'b1);
      checkOutput("done", done, prevHs && words == NREG);
      if (prevHs && words == NREG) begin
        doneCycle = cyc;
        finished = 1;
      end else if (prevHs) begin
        checkOutput("gap_valid", out_valid, 1'b0);
      end else if (prevValid) begin
        checkOutput("hold_valid", out_valid, 1'b1);
      end
      if (out_valid) begin
        checkOutput("index", out_index, expIdx);
        checkOutput("data", out_data, regs[expIdx]);
        checkOutput("raddr", dbg_raddr, expIdx);
      end
      if (finished) begin
        out_ready = 1'b0;
        @(negedge clk);
        checkOutput("busy_after", busy, 1'b0);
        checkOutput("done_after", done, 1'b0);
      end else if (resetIdx >= 0 && out_valid && out_index == resetIdx) begin
        out_ready = 1'b0;
        #2 reset = 1'b1;
        #1;
        checkOutput("rst_busy", busy, 1'b0);
        checkOutput("rst_valid", out_valid, 1'b0);
        checkOutput("rst_data", out_data, '0);
        checkOutput("rst_raddr", dbg_raddr, FIRST);
        @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 5; k++) begin
          @(negedge clk);
          checkOutput("post_rst_done", done, 1'b0);
          checkOutput("post_rst_busy", busy, 1'b0);
        end
        return;
      end else if (abortIdx >= 0 && out_valid && out_index == abortIdx) begin
        out_ready = 1'b0;
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        checkOutput("abort_busy", busy, 1'b0);
        checkOutput("abort_valid", out_valid, 1'b0);
        checkOutput("abort_done", done, 1'b0);
        for (int k = 0; k < 3; k++) begin
          @(negedge clk);
          checkOutput("post_abort_done", done, 1'b0);
        end
        return;
      end else begin
        if (stallIdx >= 0 && !stallUsed && out_valid && out_index == stallIdx) begin
          stallLeft = 5;
          stallUsed = 1;
        end
        if (stallLeft > 0) begin
          out_ready = 1'b0;
          stallLeft--;
        end else begin
          out_ready = ($urandom_range(0, 99) < readyPct);
        end
        start = (startIdx >= 0 && !startUsed && out_valid && out_index == startIdx);
        if (start) startUsed = 1;
        prevValid = out_valid;
        prevHs = out_valid && out_ready;
        if (prevHs) begin
          words++;
          expIdx++;
        end
        @(negedge clk);
        start = 1'b0;
        cyc++;
      end
    end
    if (!finished) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL timeout: dump did not finish, words=%0d required=%0d", words, NREG);
    end else begin
      checkOutput("word_count", words, NREG);
      if (checkTiming) checkOutput("dump_cycles", doneCycle, 2 * NREG + 1);
    end
  endtask

  vec_t vecs [12];

  initial begin
    reset = 1'b1; start = 1'b0; abort = 1'b0; out_ready = 1'b0;
    loadRegs(1'b0);
    repeat (3) @(negedge clk);
    checkOutput("reset_busy", busy, 1'b0);
    checkOutput("reset_valid", out_valid, 1'b0);
    checkOutput("reset_done", done, 1'b0);
    checkOutput("reset_raddr", dbg_raddr, '0);
    checkOutput("reset_data", out_data, '0);
    reset = 1'b0;
    @(negedge clk);

    vecs[0]  = '{1, 0, 0, 1, 0, 5'd0, 5'd0, 32'h0};
    vecs[1]  = '{0, 0, 0, 1, 1, 5'd0, 5'd0, 32'h0};
    vecs[2]  = '{0, 0, 0, 1, 1, 5'd0, 5'd0, 32'h0};
    vecs[3]  = '{0, 0, 1, 1, 0, 5'd1, 5'd0, 32'h0};
    vecs[4]  = '{0, 0, 1, 1, 1, 5'd1, 5'd1, 32'h1000_0001};
    vecs[5]  = '{1, 0, 1, 1, 0, 5'd2, 5'd0, 32'h0};
    vecs[6]  = '{0, 0, 0, 1, 1, 5'd2, 5'd2, 32'h1000_0002};
    vecs[7]  = '{0, 1, 0, 0, 0, 5'd2, 5'd0, 32'h0};
    vecs[8]  = '{1, 1, 0, 1, 0, 5'd0, 5'd0, 32'h0};
    vecs[9]  = '{0, 0, 1, 1, 1, 5'd0, 5'd0, 32'h0};
    vecs[10] = '{0, 1, 1, 0, 0, 5'd0, 5'd0, 32'h0};
    vecs[11] = '{0, 0, 0, 0, 0, 5'd0, 5'd0, 32'h0};
    for (int i = 0; i < 12; i++) begin
      start = vecs[i].start; abort = vecs[i].abort; out_ready = vecs[i].ready;
      @(negedge clk);
      checkOutput($sformatf("vec%0d_busy", i), busy, vecs[i].expBusy);
      checkOutput($sformatf("vec%0d_valid", i), out_valid, vecs[i].expValid);
      checkOutput($sformatf("vec%0d_raddr", i), dbg_raddr, vecs[i].expRaddr);
      checkOutput($sformatf("vec%0d_done", i), done, 1'b0);
      if (vecs[i].expValid) begin
        checkOutput($sformatf("vec%0d_index", i), out_index, vecs[i].expIndex);
        checkOutput($sformatf("vec%0d_data", i), out_data, vecs[i].expData);
      end
    end
    start = 1'b0; abort = 1'b0; out_ready = 1'b0;
    @(negedge clk);

    $display("[TB] full dump, ready high");
    applyStimulus(100, -1, -1, -1, -1, 1'b1);
    $display("[TB] backpressure on index 7");
    applyStimulus(100, 7, -1, -1, -1, 1'b0);
    $display("[TB] start while busy at index 4");
    applyStimulus(100, -1, 4, -1, -1, 1'b1);
    $display("[TB] abort at index 10, then fresh dump");
    applyStimulus(100, -1, -1, 10, -1, 1'b0);
    applyStimulus(100, -1, -1, -1, -1, 1'b1);
    $display("[TB] async reset at index 20");
    applyStimulus(100, -1, -1, -1, 20, 1'b0);

    for (int r = 0; r < 4; r++) begin
      loadRegs(1'b1);
      $display("[TB] random dump %0d", r);
      applyStimulus($urandom_range(20, 100), -1, -1, -1, -1, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/regfile_dump_reader.md
Name: regfile_dump_reader

Overview:
- Debug-side reader for the core's 32x32 register file.
- On a start pulse, walks registers FIRST_REG..LAST_REG through one borrowed asynchronous read port and streams each word out over a valid/ready interface.
- Raises busy so top level muxes dbg_raddr onto the rs1 read address and stalls the core (no register writes while busy).
- Sits between the register file and the debug/trace transport.

Parameters:
- DATA_W, 32, register width.
- ADDR_W, 5, register index width.
- FIRST_REG, 0, first index dumped.
- LAST_REG, 31, last index dumped; FIRST_REG <= LAST_REG required.

Ports:
- clk  input  1  single system clock, rising edge.
- reset  input  1  asynchronous, active-high; clears all state immediately.
- start  input  1  one-cycle request to begin a dump; sampled only in IDLE.
- abort  input  1  synchronous cancel; honoured in any non-IDLE state.
- dbg_raddr  output  ADDR_W  read address driven to register-file read port.
- dbg_rdata  input  DATA_W  combinational read data returned for dbg_raddr.
- busy  output  1  high whenever state != IDLE; core stall / port-mux select.
- out_valid  output  1  out_data/out_index hold a word.
- out_ready  input  1  sink accepts word when out_valid && out_ready at rising edge.
- out_data  output  DATA_W  captured register value.
- out_index  output  ADDR_W  register index of out_data.
- done  output  1  single-cycle pulse after last word accepted.

Behaviour:
- Reset values: state IDLE; idx=FIRST_REG; dbg_raddr=0; busy=0; out_valid=0; out_data=0; out_index=0; done=0. Reset asserted mid-dump aborts instantly: no further words, no done.
- FSM states: IDLE, READ, SEND, FIN. All state and outputs registered except dbg_raddr=idx (direct from register) and busy=(state!=IDLE).
- IDLE: start=1 -> idx<=FIRST_REG, go READ. start=0 -> stay.
- READ (one cycle): dbg_raddr=idx; at edge capture out_data<=dbg_rdata, out_index<=idx, out_valid<=1, go SEND.
- SEND: hold out_valid, out_data, out_index stable until handshake.
  - On handshake with idx<LAST_REG: out_valid<=0, idx<=idx+1, go READ.
  - On handshake with idx==LAST_REG: out_valid<=0, done<=1, go FIN.
- FIN (one cycle): done=1, then done<=0, go IDLE. busy drops in the cycle after FIN.
- Timing and throughput:
  - start sampled at edge E0: READ during cycle E0..E1; out_valid first high after E1.
  - Sustained rate is 1 word per 2 cycles with out_ready tied high.
  - Full 32-register dump, ready always high: 64 cycles from first READ to FIN, plus 1 cycle FIN.
- abort in READ/SEND/FIN: go IDLE next edge; out_valid<=0, done<=0.
  - A word handshaken in the same cycle as abort counts as delivered.
  - No done is generated on abort.
- start while not IDLE: ignored, never queued. start and abort together in IDLE: start wins (abort only acts when non-IDLE).
- Index arithmetic: idx is ADDR_W bits. Never increments past LAST_REG, so no wrap. x0 is dumped as read (expected 0).
- out_valid never deasserts without a handshake, except on abort or reset.

Decomposition:
- Shared package `rv_debug_pkg`:
  - constants REG_COUNT=32, REG_ADDR_W=5, XLEN=32;
  - state typedef enum {IDLE, READ, SEND, FIN}, also used by future debug writer/loader.
- No sub-module needed; single FSM plus index counter. Bench reuses the existing register file as the read target.

Test Plan:
- Reset: hold reset 3 cycles -> busy=0, out_valid=0, done=0, dbg_raddr=0, out_data=0.
- Full dump: preload xi=0x1000_0000+i (x0=0), out_ready=1, pulse start -> 32 words, out_index 0..31, out_data matches preload, words 2 cycles apart, done pulse exactly 1 cycle after word 31, busy low next cycle.
- Backpressure: out_ready=0 for 5 cycles on index 7 -> out_valid held, out_data=0x1000_0007 stable, no idx advance; release -> index 8 follows 2 cycles later.
- Start while busy: pulse start during index 4 -> ignored, dump completes with exactly 32 words and one done.
- Abort: assert abort in SEND at index 10 with out_ready=0 -> next cycle IDLE, out_valid=0, busy=0, no done; a new start then dumps from index 0.
- Async reset mid-dump: assert reset between edges at index 20 -> outputs clear immediately without a clock edge; no done after release.
